// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and round functions for the iterative core.
package sha256_pkg;

   typedef logic [31:0] word_t;
   typedef word_t [0:7] state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ROUND = 2'd1;
   localparam logic [1:0] ST_FINAL = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam state_t IV_256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam state_t IV_224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

   localparam word_t K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t bsig0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t bsig1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t ssig0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t ssig1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic word_t ch(input word_t e, input word_t f, input word_t g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic word_t maj(input word_t a, input word_t b, input word_t c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round; working state packed a (word 0) .. h (word 7).
module sha256_round
   import sha256_pkg::*;
(
   input  logic [255:0] s_in,
   input  logic [31:0]  k,
   input  logic [31:0]  w,
   output logic [255:0] s_out
);

   state_t s;
   state_t n;
   word_t  t1;
   word_t  t2;

   always_comb begin
      s  = s_in;
      t1 = s[7] + bsig1(s[4]) + ch(s[4], s[5], s[6]) + k + w;
      t2 = bsig0(s[0]) + maj(s[0], s[1], s[2]);
      n  = {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
   end

   assign s_out = n;

endmodule

// File: rtl/sha256_core_iter.sv
// Iterative SHA-256/224 compression engine, ROUNDS_PER_CYCLE rounds per clock.
//   state    | meaning
//   IDLE     | waiting for a block, in_ready=1
//   ROUND    | ROUNDS_PER_CYCLE rounds per cycle, NUM_STEPS cycles
//   FINAL    | fold working vars into chaining value, publish digest
//   DONE     | holding out_valid until out_ready
module sha256_core_iter
   import sha256_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_block,
   input  logic         in_first,
   input  logic         in_sha224,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_digest,
   output logic         busy
);

   localparam int R         = ROUNDS_PER_CYCLE;
   localparam int NUM_STEPS = 64 / R;

   if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds
      $error("sha256_core_iter: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   logic [1:0]      state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   word_t [0:15]    win_q, win_d;
   state_t          h_q, h_d;
   state_t          work_q, work_d;
   state_t          digest_q, digest_d;
   logic            mode224_q, mode224_d;
   logic            out_valid_q, out_valid_d;

   word_t           w_ext [0:15+R];
   logic [5:0]      t_base;
   logic [255:0]    rounds_out;

   assign t_base = 6'(cnt_q * 6'(R));

   // Window extended by R freshly scheduled words; later ones may depend on earlier ones.
   always_comb begin
      word_t x [0:15+R];
      for (int j = 0; j < 16; j++) x[j] = win_q[j];
      for (int j = 0; j < R; j++)
         x[16+j] = x[j] + ssig0(x[j+1]) + x[j+9] + ssig1(x[j+14]);
      w_ext = x;
   end

   for (genvar i = 0; i < R; i++) begin : g_rnd
      logic [255:0] s_in;
      logic [255:0] s_out;
      if (i == 0) begin : g_first
         assign s_in = work_q;
      end else begin : g_next
         assign s_in = g_rnd[i-1].s_out;
      end
      sha256_round u_round (
         .s_in  (s_in),
         .k     (K[6'(t_base + 6'(i))]),
         .w     (w_ext[i]),
         .s_out (s_out)
      );
   end

   assign rounds_out = g_rnd[R-1].s_out;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      win_d       = win_q;
      h_d         = h_q;
      work_d      = work_q;
      digest_d    = digest_q;
      mode224_d   = mode224_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               win_d = in_block;
               if (in_first) begin
                  h_d       = in_sha224 ? IV_224 : IV_256;
                  mode224_d = in_sha224;
               end
               work_d  = h_d;
               cnt_d   = '0;
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
            work_d = rounds_out;
            for (int j = 0; j < 16; j++) win_d[j] = w_ext[j+R];
            if (cnt_q == 6'(NUM_STEPS - 1)) begin
               cnt_d   = '0;
               state_d = ST_FINAL;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         ST_FINAL: begin
            for (int j = 0; j < 8; j++) h_d[j] = h_q[j] + work_q[j];
            digest_d = h_d;
            if (mode224_q) digest_d[7] = '0;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         win_q       <= '0;
         h_q         <= IV_256;
         work_q      <= '0;
         digest_q    <= '0;
         mode224_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         win_q       <= win_d;
         h_q         <= h_d;
         work_q      <= work_d;
         digest_q    <= digest_d;
         mode224_q   <= mode224_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready   = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign out_valid  = out_valid_q;
   assign out_digest = digest_q;

endmodule
